// File: rtl/sprite_palette_bank_if.sv
// sprite_palette_bank_if: bus bundle for the sprite palette bank.
//   lookup request : lk_valid, lk_pal_sel, lk_index
//   lookup result  : out_valid, out_red, out_green, out_blue, out_transparent
//   shadow write   : wr_en, wr_pal, wr_index, wr_data ({R,G,B})
//   commit control : commit_req, frame_start, commit_pending
// master = pixel/CPU side driving requests, slave = the palette bank.
interface sprite_palette_bank_if #(
    parameter int NUM_PALETTES = 4,
    parameter int INDEX_W      = 4,
    parameter int COLOR_W      = 4
);
    localparam int PSEL_W = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
    logic                 lk_valid;
    logic [PSEL_W-1:0]    lk_pal_sel;
    logic [INDEX_W-1:0]   lk_index;
    logic                 out_valid;
    logic [COLOR_W-1:0]   out_red;
    logic [COLOR_W-1:0]   out_green;
    logic [COLOR_W-1:0]   out_blue;
    logic                 out_transparent;
    logic                 wr_en;
    logic [PSEL_W-1:0]    wr_pal;
    logic [INDEX_W-1:0]   wr_index;
    logic [3*COLOR_W-1:0] wr_data;
    logic                 commit_req;
    logic                 frame_start;
    logic                 commit_pending;

    modport master (
        output lk_valid, lk_pal_sel, lk_index, wr_en, wr_pal, wr_index, wr_data,
               commit_req, frame_start,
        input  out_valid, out_red, out_green, out_blue, out_transparent, commit_pending
    );
    modport slave (
        input  lk_valid, lk_pal_sel, lk_index, wr_en, wr_pal, wr_index, wr_data,
               commit_req, frame_start,
        output out_valid, out_red, out_green, out_blue, out_transparent, commit_pending
    );
endinterface

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: multi-palette colour lookup with shadow/active copies.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : sprite_palette_bank_if.slave (lookup, result, shadow write, commit)
// Lookups take two cycles (register request, then read active and register
// result). Edits land in shadow and are copied to active on one edge at a
// frame boundary, so the displayed image never tears.
module sprite_palette_bank #(
    parameter int NUM_PALETTES = 4,
    parameter int INDEX_W      = 4,
    parameter int COLOR_W      = 4,
    parameter int TRANSP_EN    = 1,
    parameter int TRANSP_IDX   = 0
) (
    input logic                  clk,
    input logic                  rst_n,
    sprite_palette_bank_if.slave bus
);
    localparam int PSEL_W = (NUM_PALETTES > 1) ? $clog2(NUM_PALETTES) : 1;
    localparam int DEPTH  = 1 << INDEX_W;
    localparam int EW     = 3 * COLOR_W;
    // One extra bit so a limit equal to 2^PSEL_W is still representable.
    localparam logic [PSEL_W:0] PAL_LIMIT = (PSEL_W+1)'(NUM_PALETTES);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t              state, state_nxt;
    logic                do_copy;
    logic [EW-1:0]       active [NUM_PALETTES][DEPTH];
    logic [EW-1:0]       shadow [NUM_PALETTES][DEPTH];
    logic                s1_valid;
    logic [PSEL_W-1:0]   s1_pal;
    logic [INDEX_W-1:0]  s1_idx;
    logic                s1_pal_ok;
    logic                wr_pal_ok;
    logic [EW-1:0]       rd_entry;

    assign wr_pal_ok = {1'b0, bus.wr_pal} < PAL_LIMIT;
    assign s1_pal_ok = {1'b0, s1_pal} < PAL_LIMIT;
    assign rd_entry  = s1_pal_ok ? active[s1_pal][s1_idx] : '0;
    assign bus.commit_pending = (state == ARMED);

    // A request on a frame_start edge commits immediately; otherwise it arms
    // and waits. Extra requests while armed merge into the same commit.
    always_comb begin
        do_copy   = bus.frame_start && (bus.commit_req || state == ARMED);
        state_nxt = do_copy ? IDLE : (bus.commit_req ? ARMED : state);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PALETTES; p++)
                for (int i = 0; i < DEPTH; i++)
                    shadow[p][i] <= '0;
        end else if (bus.wr_en && wr_pal_ok) begin
            shadow[bus.wr_pal][bus.wr_index] <= bus.wr_data;
        end
    end

    // Copy samples shadow before any same-edge write reaches it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PALETTES; p++)
                for (int i = 0; i < DEPTH; i++)
                    active[p][i] <= '0;
        end else if (do_copy) begin
            active <= shadow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_pal   <= '0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= bus.lk_valid;
            s1_pal   <= bus.lk_pal_sel;
            s1_idx   <= bus.lk_index;
        end
    end

    // Result fields hold their last value while no lookup is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid       <= 1'b0;
            bus.out_red         <= '0;
            bus.out_green       <= '0;
            bus.out_blue        <= '0;
            bus.out_transparent <= 1'b0;
        end else begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                {bus.out_red, bus.out_green, bus.out_blue} <= rd_entry;
                bus.out_transparent <= s1_pal_ok ?
                    ((TRANSP_EN != 0) && (s1_idx == INDEX_W'(TRANSP_IDX))) : 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sprite_palette_bank.sv
// tb_sprite_palette_bank: randomized + directed bench for sprite_palette_bank
// against an array-based reference model of the palette bank behaviour.
module tb_sprite_palette_bank;
    localparam int NP = 3;
    localparam int IW = 4;
    localparam int CW = 4;
    localparam int TI = 0;
    localparam int PW = 2;
    localparam int DEPTH = 1 << IW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sprite_palette_bank_if #(.NUM_PALETTES(NP), .INDEX_W(IW), .COLOR_W(CW)) bus ();

    sprite_palette_bank #(
        .NUM_PALETTES(NP), .INDEX_W(IW), .COLOR_W(CW), .TRANSP_EN(1), .TRANSP_IDX(TI)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    logic [11:0] m_act [NP][DEPTH];
    logic [11:0] m_sh  [NP][DEPTH];
    bit          m_pend;
    bit          p_v;
    int          p_pal, p_idx;
    bit          e_v, e_t;
    logic [11:0] e_rgb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++)
            for (int i = 0; i < DEPTH; i++) begin
                m_act[p][i] = '0;
                m_sh[p][i]  = '0;
            end
        m_pend = 0; p_v = 0; p_pal = 0; p_idx = 0;
        e_v = 0; e_t = 0; e_rgb = '0;
    endtask

    // One clock edge of the palette bank as described behaviourally.
    task automatic model_edge();
        bit cp;
        if (p_v) begin
            e_v = 1;
            if (p_pal < NP) begin
                e_rgb = m_act[p_pal][p_idx];
                e_t = (p_idx == TI);
            end else begin
                e_rgb = '0;
                e_t = 1;
            end
        end else e_v = 0;
        p_v = bus.lk_valid;
        p_pal = int'(bus.lk_pal_sel);
        p_idx = int'(bus.lk_index);
        cp = bus.frame_start && (bus.commit_req || m_pend);
        if (cp) m_act = m_sh;
        if (bus.wr_en && int'(bus.wr_pal) < NP) m_sh[bus.wr_pal][bus.wr_index] = bus.wr_data;
        m_pend = !cp && (bus.commit_req || m_pend);
    endtask

    task automatic compare();
        check("out_valid", 32'(bus.out_valid), 32'(e_v));
        check("out_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'(e_rgb));
        check("out_transparent", 32'(bus.out_transparent), 32'(e_t));
        check("commit_pending", 32'(bus.commit_pending), 32'(m_pend));
    endtask

    task automatic cyc(input bit lv, input int pal, input int idx, input bit we, input int wp,
                       input int wi, input logic [11:0] wd, input bit cr, input bit fs);
        bus.lk_valid = lv; bus.lk_pal_sel = PW'(pal); bus.lk_index = IW'(idx);
        bus.wr_en = we; bus.wr_pal = PW'(wp); bus.wr_index = IW'(wi); bus.wr_data = wd;
        bus.commit_req = cr; bus.frame_start = fs;
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic lk(input int pal, input int idx);
        cyc(1, pal, idx, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, '0, 0, 0);
    endtask

    task automatic wr(input int pal, input int idx, input logic [11:0] d);
        cyc(0, 0, 0, 1, pal, idx, d, 0, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        compare();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        bus.lk_valid = 0; bus.lk_pal_sel = '0; bus.lk_index = '0;
        bus.wr_en = 0; bus.wr_pal = '0; bus.wr_index = '0; bus.wr_data = '0;
        bus.commit_req = 0; bus.frame_start = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        compare();
        rst_n = 1'b1;

        // every palette/index after reset, including out-of-range palette 3
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < DEPTH; i++) lk(p, i);
        idle(); idle();

        // write without commit stays invisible
        wr(1, 5, 12'h942);
        lk(1, 5); idle();
        check("pre_commit_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h000);
        cyc(0, 0, 0, 0, 0, 0, '0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, '0, 0, 1);
        lk(1, 5); idle();
        check("post_commit_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h942);

        // deferred commit: request, wait 40 cycles, lookup straddling the copy edge
        wr(1, 5, 12'h123);
        cyc(0, 0, 0, 0, 0, 0, '0, 1, 0);
        check("armed", 32'(bus.commit_pending), 32'h1);
        repeat (38) idle();
        cyc(0, 0, 0, 0, 0, 0, '0, 1, 0);
        lk(1, 5);
        cyc(1, 1, 5, 0, 0, 0, '0, 0, 1);
        check("copy_edge_old", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h942);
        check("disarmed", 32'(bus.commit_pending), 32'h0);
        idle();
        check("after_copy_new", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h123);

        // write on the copy edge lands only in shadow
        cyc(0, 0, 0, 1, 0, 3, 12'hFF0, 1, 1);
        lk(0, 3); idle();
        check("wr_on_copy_old", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h000);
        cyc(0, 0, 0, 0, 0, 0, '0, 1, 1);
        lk(0, 3); idle();
        check("wr_on_copy_new", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'hFF0);

        // transparency and out-of-range palette
        wr(2, 0, 12'h5A5);
        cyc(0, 0, 0, 0, 0, 0, '0, 1, 1);
        lk(2, 0); idle();
        check("transp_idx", 32'(bus.out_transparent), 32'h1);
        check("transp_rgb_kept", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h5A5);
        lk(3, 7); idle();
        check("bad_pal_transp", 32'(bus.out_transparent), 32'h1);
        check("bad_pal_rgb", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h000);
        for (int i = 0; i < DEPTH; i++) wr(3, i, 12'hABC);
        cyc(0, 0, 0, 0, 0, 0, '0, 1, 1);
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < DEPTH; i++) lk(p, i);
        idle();

        // back-to-back lookups
        for (int i = 0; i < DEPTH; i++) wr(i % NP, i, 12'($urandom));
        cyc(0, 0, 0, 0, 0, 0, '0, 1, 1);
        for (int i = 0; i < 16; i++) lk($urandom_range(0, 3), $urandom_range(0, DEPTH - 1));
        idle(); idle();

        // reset while armed discards the commit
        cyc(0, 0, 0, 0, 0, 0, '0, 1, 0);
        check("armed_before_reset", 32'(bus.commit_pending), 32'h1);
        do_reset();
        check("reset_disarms", 32'(bus.commit_pending), 32'h0);
        wr(0, 1, 12'hABC);
        cyc(0, 0, 0, 0, 0, 0, '0, 0, 1);
        lk(0, 1); idle();
        check("no_copy_after_reset", 32'({bus.out_red, bus.out_green, bus.out_blue}), 32'h000);

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cyc($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, DEPTH - 1),
                12'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_palette_bank.md
Name: sprite_palette_bank

Overview:
- Multi-palette, runtime-programmable colour lookup for sprite rendering.
- Replaces the fixed per-sprite palette ROMs. Holds NUM_PALETTES palettes of 2^INDEX_W entries each.
- A sprite pixel's palette select plus colour index produces an RGB output through a 2-stage pipeline, with a transparency flag.
- Palette edits go to a shadow copy and are committed to the active copy only at a frame boundary, so the on-screen image never tears.

Parameters:
- NUM_PALETTES, 4, number of palettes (1..16; need not be a power of two).
- INDEX_W, 4, colour index width; palette depth = 2^INDEX_W.
- COLOR_W, 4, bits per colour channel; entry width = 3*COLOR_W, packed {R,G,B}.
- TRANSP_EN, 1, 1 = index TRANSP_IDX is reported transparent.
- TRANSP_IDX, 0, colour index treated as transparent.
- PSEL_W, $clog2(NUM_PALETTES) (min 1), palette select width (derived).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- lk_valid  in  1  lookup request valid
- lk_pal_sel  in  PSEL_W  palette select for the lookup
- lk_index  in  INDEX_W  colour index for the lookup
- out_valid  out  1  lookup result valid
- out_red  out  COLOR_W  red channel
- out_green  out  COLOR_W  green channel
- out_blue  out  COLOR_W  blue channel
- out_transparent  out  1  pixel is transparent / invalid
- wr_en  in  1  shadow palette write strobe
- wr_pal  in  PSEL_W  palette being written
- wr_index  in  INDEX_W  entry being written
- wr_data  in  3*COLOR_W  entry value, {R,G,B}
- commit_req  in  1  one-cycle pulse: request shadow->active copy
- frame_start  in  1  one-cycle pulse at start of vertical blank
- commit_pending  out  1  a commit is armed and waiting for frame_start

Behaviour:
- Storage: two register arrays, active[NUM_PALETTES][2^INDEX_W] and shadow[same], each entry 3*COLOR_W bits.
- Reset (rst_n low, asynchronous):
  - All active and shadow entries = 0.
  - out_valid = 0, out_red/green/blue = 0, out_transparent = 0, commit_pending = 0.
  - Pipeline valid bits = 0.
  - Reset mid-frame discards any pending commit and any in-flight lookups.
- Lookup pipeline (fully pipelined, one lookup per cycle, no backpressure):
  - Stage 1 (edge N): register lk_valid, lk_pal_sel and lk_index.
  - Stage 2 (edge N+1): read active[pal][idx] and register it onto out_* with out_valid.
  - Latency is exactly 2 cycles from lk_valid high to out_valid high.
  - When the stage-1 valid bit is 0: out_valid = 0 and out_red/green/blue/out_transparent hold their previous values.
- Transparency:
  - out_transparent = 1 when TRANSP_EN = 1 and idx == TRANSP_IDX. The RGB output still carries the stored entry.
  - When pal >= NUM_PALETTES: out_transparent = 1 and RGB = 0.
- Shadow write:
  - On an edge with wr_en = 1 and wr_pal < NUM_PALETTES, shadow[wr_pal][wr_index] <= wr_data.
  - wr_pal >= NUM_PALETTES: write is ignored.
  - Writes never affect active directly.
- Commit control (2-state FSM, IDLE / ARMED; commit_pending = ARMED):
  - IDLE, commit_req = 1, frame_start = 0 -> ARMED.
  - IDLE, commit_req = 1, frame_start = 1 -> copy this edge, stay IDLE.
  - ARMED, frame_start = 1 -> copy this edge, go to IDLE.
  - ARMED, commit_req = 1 -> stay ARMED; repeated requests merge into one commit.
  - Copy = every active entry <= the corresponding shadow entry, on a single edge. Shadow is unchanged, so later partial edits accumulate on the committed image.
  - frame_start with no request: no effect.
- Simultaneous events:
  - Write on the copy edge: the copy uses pre-write shadow contents; the write lands in shadow only and is visible after the next commit.
  - Lookup whose stage-2 read happens on the copy edge: returns the old active value. The new value is returned from the following cycle.
  - commit_req on the same edge as a copy from ARMED: FSM goes to IDLE, and the request is absorbed into that copy.

Test Plan:
- Reset check: reset, then lookups on every pal/idx -> all RGB = 0, out_valid high exactly 2 cycles after each lk_valid.
- Write then lookup, no commit: write shadow[1][5] = 12'h942, then look up pal 1 idx 5 -> RGB = 0,0,0. Pulse commit_req then frame_start, look up again -> R = 9, G = 4, B = 2.
- Deferred commit: commit_req at cycle 10, frame_start at cycle 50 -> commit_pending high on cycles 11..50, active changes only at the cycle-50 edge. A lookup read on that edge returns the old value; the next one returns the new value.
- Write on the copy edge: write shadow[0][3] = 12'hFF0 on the same edge as the copy -> active[0][3] keeps its old value. After a second commit -> 12'hFF0.
- Transparency and range: TRANSP_IDX = 0, look up pal 2 idx 0 -> out_transparent = 1. With NUM_PALETTES = 3, look up pal 3 -> out_transparent = 1, RGB = 0. A write to pal 3 leaves all entries unchanged.
- Throughput and reset: back-to-back lookups for 16 cycles -> 16 consecutive results in order. Assert rst_n low while ARMED -> commit_pending = 0, and the following frame_start does not copy.
